smj_seq_judge: RTL

//  Streaming, parametrised successor of the 5-tile combinational hand judge.
//  - Takes one 6-bit tile per cycle ({suit[5:4], rank[3:0]}; suit 00 = honor) and builds a 34-kind count table.
//  - Then searches sequentially for a decomposition into N_MELDS melds plus one pair.
//  - Sits between the tile-stream front end and the scoring stage.

---
 rtl/smj_pkg.sv | 54 +++++
 rtl/smj_tile_decode.sv | 13 +
 rtl/smj_seq_judge.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/smj_pkg.sv
// Shared types, tile/kind mapping helpers and result codes for the streaming hand judge.
package smj_pkg;

    localparam int NUM_KINDS = 34;

    typedef logic [5:0] tile_t;

    typedef enum logic [1:0] {
        SUIT_HONOR = 2'd0,
        SUIT_S1    = 2'd1,
        SUIT_S2    = 2'd2,
        SUIT_S3    = 2'd3
    } suit_e;

    localparam logic [1:0] RES_NONE    = 2'b00;
    localparam logic [1:0] RES_INVALID = 2'b01;
    localparam logic [1:0] RES_SEQ     = 2'b10;
    localparam logic [1:0] RES_TRIPLET = 2'b11;

    function automatic logic tile_is_legal(tile_t t);
        if (suit_e'(t[5:4]) == SUIT_HONOR) return (t[3:0] <= 4'd6);
        return (t[3:0] <= 4'd8);
    endfunction

    // Kinds are ordered honors 0..6, then each number suit in blocks of nine.
    function automatic logic [5:0] tile_to_kind(tile_t t);
        logic [5:0] base;
        case (t[5:4])
            2'd0:    base = 6'd0;
            2'd1:    base = 6'd7;
            2'd2:    base = 6'd16;
            default: base = 6'd25;
        endcase
        return base + {2'b00, t[3:0]};
    endfunction

    function automatic tile_t kind_to_tile(logic [5:0] k);
        if (k < 6'd7)  return {2'b00, 4'(k)};
        if (k < 6'd16) return {2'b01, 4'(k - 6'd7)};
        if (k < 6'd25) return {2'b10, 4'(k - 6'd16)};
        return {2'b11, 4'(k - 6'd25)};
    endfunction

    function automatic logic kind_is_number(logic [5:0] k);
        return (k >= 6'd7);
    endfunction

    function automatic logic [3:0] kind_rank(logic [5:0] k);
        tile_t t;
        t = kind_to_tile(k);
        return t[3:0];
    endfunction

endpackage

// File: rtl/smj_tile_decode.sv
// Combinational tile decoder: legality check and kind index for the count table.
module smj_tile_decode
    import smj_pkg::*;
(
    input  tile_t      tile,
    output logic       legal,
    output logic [5:0] kind
);

    assign legal = tile_is_legal(tile);
    assign kind  = tile_to_kind(tile);

endmodule

// File: rtl/smj_seq_judge.sv
// Streaming hand judge: collects HAND_SIZE tiles, then searches pair candidates sequentially.
// Optional out_pair port enabled by defining SMJ_PAIR_OUT_EN.
module smj_seq_judge
    import smj_pkg::*;
#(
    parameter  int N_MELDS    = 1,
    parameter  int MAX_COPIES = 4,
    localparam int HAND_SIZE  = 3 * N_MELDS + 2,
    localparam int CNT_W      = $clog2(HAND_SIZE + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [5:0] in_tile,
    output logic       in_ready,
    output logic       out_valid,
    output logic [1:0] out_data
`ifdef SMJ_PAIR_OUT_EN
    ,
    output logic [5:0] out_pair
`endif
);

    typedef enum logic [2:0] {S_COLLECT, S_CHECK, S_PAIR_SEL, S_SCAN, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q  [NUM_KINDS];
    logic [CNT_W-1:0] work_q [NUM_KINDS+2];  // two zero pad entries keep i+1/i+2 reads in range
    logic [CNT_W-1:0] tile_cnt_q, seq_cnt_q, rem, seq_new;
    logic [5:0]       p_q, i_q, tile_kind;
    logic             bad_q, tri_q, seq_q, out_valid_q, tile_legal;
    logic             accept, over, scan_ok, last_p, last_i, hand_bad;
    logic [1:0]       out_data_q;
`ifdef SMJ_PAIR_OUT_EN
    logic [5:0]       pair_q, out_pair_q;
    assign out_pair = out_pair_q;
`endif

    smj_tile_decode u_dec (
        .tile  (in_tile),
        .legal (tile_legal),
        .kind  (tile_kind)
    );

    assign in_ready  = (state_q == S_COLLECT);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign accept    = in_valid & in_ready;
    assign last_p    = (p_q == 6'(NUM_KINDS - 1));
    assign last_i    = (i_q == 6'(NUM_KINDS - 1));
    assign hand_bad  = bad_q | over;

    always_comb begin
        over    = 1'b0;
        rem     = work_q[i_q] % CNT_W'(3);
        seq_new = seq_cnt_q + rem;
        scan_ok = 1'b0;
        state_d = state_q;
        for (int k = 0; k < NUM_KINDS; k++)
            if (int'(cnt_q[k]) > MAX_COPIES) over = 1'b1;
        // Leftover after triplets must start a same-suit run entirely inside the suit.
        if (rem == '0)
            scan_ok = 1'b1;
        else if (kind_is_number(i_q) && (kind_rank(i_q) <= 4'd6) &&
                 (work_q[i_q + 6'd1] >= rem) && (work_q[i_q + 6'd2] >= rem))
            scan_ok = 1'b1;
        case (state_q)
            S_COLLECT:  if (accept && (tile_cnt_q == CNT_W'(HAND_SIZE - 1))) state_d = S_CHECK;
            S_CHECK:    state_d = hand_bad ? S_COLLECT : S_PAIR_SEL;
            S_PAIR_SEL: begin
                if (cnt_q[p_q] >= CNT_W'(2)) state_d = S_SCAN;
                else if (last_p)             state_d = S_DONE;
            end
            S_SCAN: begin
                if (!scan_ok || last_i) begin
                    if (scan_ok && (seq_new == '0)) state_d = S_DONE;
                    else                            state_d = last_p ? S_DONE : S_PAIR_SEL;
                end
            end
            S_DONE:     state_d = S_COLLECT;
            default:    state_d = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_COLLECT;
            tile_cnt_q  <= '0;
            seq_cnt_q   <= '0;
            p_q         <= '0;
            i_q         <= '0;
            bad_q       <= 1'b0;
            tri_q       <= 1'b0;
            seq_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= RES_NONE;
            for (int k = 0; k < NUM_KINDS; k++) cnt_q[k] <= '0;
`ifdef SMJ_PAIR_OUT_EN
            pair_q      <= '0;
            out_pair_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= 1'b0;
            case (state_q)
                S_COLLECT: begin
                    if (accept) begin
                        tile_cnt_q <= tile_cnt_q + CNT_W'(1);
                        if (tile_legal) cnt_q[tile_kind] <= cnt_q[tile_kind] + CNT_W'(1);
                        else            bad_q <= 1'b1;
                    end
                end
                S_CHECK: begin
                    p_q   <= '0;
                    tri_q <= 1'b0;
                    seq_q <= 1'b0;
`ifdef SMJ_PAIR_OUT_EN
                    pair_q <= '0;
`endif
                    if (hand_bad) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= RES_INVALID;
                        tile_cnt_q  <= '0;
                        bad_q       <= 1'b0;
                        for (int k = 0; k < NUM_KINDS; k++) cnt_q[k] <= '0;
`ifdef SMJ_PAIR_OUT_EN
                        out_pair_q  <= '0;
`endif
                    end
                end
                S_PAIR_SEL: begin
                    if (cnt_q[p_q] >= CNT_W'(2)) begin
                        for (int k = 0; k < NUM_KINDS; k++) work_q[k] <= cnt_q[k];
                        work_q[NUM_KINDS]     <= '0;
                        work_q[NUM_KINDS + 1] <= '0;
                        work_q[p_q]           <= cnt_q[p_q] - CNT_W'(2);
                        seq_cnt_q             <= '0;
                        i_q                   <= '0;
                    end else begin
                        p_q <= p_q + 6'd1;
                    end
                end
                S_SCAN: begin
                    if (!scan_ok) begin
                        p_q <= p_q + 6'd1;
                    end else begin
                        work_q[i_q + 6'd1] <= work_q[i_q + 6'd1] - rem;
                        work_q[i_q + 6'd2] <= work_q[i_q + 6'd2] - rem;
                        seq_cnt_q          <= seq_new;
                        i_q                <= i_q + 6'd1;
                        if (last_i) begin
                            if (seq_new == '0) begin
                                tri_q <= 1'b1;
`ifdef SMJ_PAIR_OUT_EN
                                pair_q <= kind_to_tile(p_q);
`endif
                            end else begin
                                seq_q <= 1'b1;
                                p_q   <= p_q + 6'd1;
`ifdef SMJ_PAIR_OUT_EN
                                if (!seq_q) pair_q <= kind_to_tile(p_q);
`endif
                            end
                        end
                    end
                end
                S_DONE: begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= tri_q ? RES_TRIPLET : (seq_q ? RES_SEQ : RES_NONE);
                    tile_cnt_q  <= '0;
                    bad_q       <= 1'b0;
                    for (int k = 0; k < NUM_KINDS; k++) cnt_q[k] <= '0;
`ifdef SMJ_PAIR_OUT_EN
                    out_pair_q  <= (tri_q || seq_q) ? pair_q : 6'd0;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
